// File: rtl/sorted_dist_serializer.sv
// +--------------------------------------------------------------------------+
// | sorted_dist_serializer: captures a sorted frame and streams it one       |
// | element per handshake. Define SORTER_DEDUP_EN to skip repeated values.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module sorted_dist_serializer #(
  parameter int WIDTH = 3,
  parameter int N     = 8,
  localparam int IW   = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] c_in,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [IW-1:0]      out_idx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               busy
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t             state_q;
  logic [N*WIDTH-1:0] frame_q;
  logic [IW-1:0]      idx_q;

  logic [IW-1:0]      nxt_idx_d;
  logic [WIDTH-1:0]   nxt_data_d;
  logic               nxt_last_d;
  logic               first_last_d;

  function automatic logic [WIDTH-1:0] elem(input logic [N*WIDTH-1:0] f, input int k);
    return f[k*WIDTH +: WIDTH];
  endfunction

  // Successor of the element currently presented, and whether it closes the frame.
  always_comb begin
    nxt_idx_d = idx_q + IW'(1);
`ifdef SORTER_DEDUP_EN
    // Descending scan so the lowest qualifying rank wins.
    for (int j = N - 1; j >= 0; j--) begin
      if (j > int'(idx_q) && elem(frame_q, j) != elem(frame_q, int'(idx_q))) begin
        nxt_idx_d = IW'(j);
      end
    end
`endif
    nxt_data_d = elem(frame_q, int'(nxt_idx_d));
`ifdef SORTER_DEDUP_EN
    nxt_last_d   = (nxt_idx_d == IW'(N - 1)) || (elem(frame_q, N - 1) == nxt_data_d);
    first_last_d = (elem(c_in, N - 1) == elem(c_in, 0));
`else
    nxt_last_d   = (nxt_idx_d == IW'(N - 1));
    first_last_d = (N == 1);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      frame_q   <= '0;
      idx_q     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q   <= STREAM;
            frame_q   <= c_in;
            idx_q     <= '0;
            out_data  <= elem(c_in, 0);
            out_valid <= 1'b1;
            out_last  <= first_last_d;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
          end
        end
        STREAM: begin
          if (out_ready) begin
            if (out_last) begin
              state_q   <= IDLE;
              idx_q     <= '0;
              out_data  <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
            end else begin
              idx_q    <= nxt_idx_d;
              out_data <= nxt_data_d;
              out_last <= nxt_last_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_idx = idx_q;

endmodule

`default_nettype wire
